// File: rtl/wb_target_slice.sv
// Registered Wishbone classic slice for one interconnect target port: one register
// stage on request and response paths, plus a per-transaction timeout that forces err.
module wb_target_slice #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [ADDR_WIDTH-1:0]     adr,
   input  logic [DATA_WIDTH-1:0]     dat_w,
   input  logic [(DATA_WIDTH/8)-1:0] sel,
   input  logic                      we,
   input  logic                      cyc,
   input  logic                      stb,
   output logic [DATA_WIDTH-1:0]     dat_r,
   output logic                      ack,
   output logic                      err,
   output logic [ADDR_WIDTH-1:0]     t_adr,
   output logic [DATA_WIDTH-1:0]     t_dat_w,
   output logic [(DATA_WIDTH/8)-1:0] t_sel,
   output logic                      t_we,
   output logic                      t_cyc,
   output logic                      t_stb,
   input  logic [DATA_WIDTH-1:0]     t_dat_r,
   input  logic                      t_ack,
   input  logic                      t_err,
   output logic                      timeout
);

   localparam int CNT_W     = (TIMEOUT < 3) ? 2 : $clog2(TIMEOUT + 1);
   localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             abort_r;
   logic             abort_s;
   logic             timeout_hit_s;
   logic             done_s;

   // Abort is sticky once the initiator drops cyc; the target side still completes.
   always_comb begin
      abort_s = abort_r | ~cyc;
      if (TIMEOUT != 0) begin
         timeout_hit_s = (cnt_r == TO_LAST);
      end else begin
         timeout_hit_s = 1'b0;
      end
      done_s = t_err | t_ack | timeout_hit_s;
   end

   // Slice FSM with all outputs registered.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         abort_r <= 1'b0;
         dat_r   <= {DATA_WIDTH{1'b0}};
         ack     <= 1'b0;
         err     <= 1'b0;
         timeout <= 1'b0;
         t_adr   <= {ADDR_WIDTH{1'b0}};
         t_dat_w <= {DATA_WIDTH{1'b0}};
         t_sel   <= {(DATA_WIDTH/8){1'b0}};
         t_we    <= 1'b0;
         t_cyc   <= 1'b0;
         t_stb   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               ack     <= 1'b0;
               err     <= 1'b0;
               timeout <= 1'b0;
               if (cyc && stb) begin
                  t_adr   <= adr;
                  t_dat_w <= dat_w;
                  t_sel   <= sel;
                  t_we    <= we;
                  t_cyc   <= 1'b1;
                  t_stb   <= 1'b1;
                  cnt_r   <= {CNT_W{1'b0}};
                  abort_r <= 1'b0;
                  state_r <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (cnt_r != CNT_MAX) begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
               abort_r <= abort_s;
               if (done_s) begin
                  t_cyc <= 1'b0;
                  t_stb <= 1'b0;
                  if (abort_s) begin
                     state_r <= ST_IDLE;
                  end else begin
                     state_r <= ST_RSP;
                     // Target error beats a simultaneous ack; a real response beats the timeout.
                     if (t_err) begin
                        err   <= 1'b1;
                        dat_r <= {DATA_WIDTH{1'b0}};
                     end else if (t_ack) begin
                        ack   <= 1'b1;
                        dat_r <= t_dat_r;
                     end else begin
                        err     <= 1'b1;
                        timeout <= 1'b1;
                        dat_r   <= {DATA_WIDTH{1'b0}};
                     end
                  end
               end
            end
            ST_RSP: begin
               ack     <= 1'b0;
               err     <= 1'b0;
               timeout <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               ack     <= 1'b0;
               err     <= 1'b0;
               timeout <= 1'b0;
               t_cyc   <= 1'b0;
               t_stb   <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_target_slice.sv
// Self-checking bench for wb_target_slice: directed table, hand-written corner
// sequences and randomized transactions against a rule-level reference model.
module tb_wb_target_slice;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;
   localparam int K_ACK = 0;
   localparam int K_ERR = 1;
   localparam int K_SIL = 2;
   localparam logic [31:0] B2B_KEY = 32'h5A5A_5A5A;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [AW-1:0] adr;
   logic [DW-1:0] dat_w;
   logic [3:0]    sel;
   logic          we, cyc, stb;
   logic [DW-1:0] dat_r;
   logic          ack, err;
   logic [AW-1:0] t_adr;
   logic [DW-1:0] t_dat_w;
   logic [3:0]    t_sel;
   logic          t_we, t_cyc, t_stb;
   logic [DW-1:0] t_dat_r;
   logic          t_ack, t_err;
   logic          timeout;

   always #5 clock = ~clock;

   wb_target_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clock(clock), .reset_n(reset_n),
      .adr(adr), .dat_w(dat_w), .sel(sel), .we(we), .cyc(cyc), .stb(stb),
      .dat_r(dat_r), .ack(ack), .err(err),
      .t_adr(t_adr), .t_dat_w(t_dat_w), .t_sel(t_sel), .t_we(t_we),
      .t_cyc(t_cyc), .t_stb(t_stb),
      .t_dat_r(t_dat_r), .t_ack(t_ack), .t_err(t_err),
      .timeout(timeout)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] wdat;
      logic [3:0]  sel;
      int          waits;
      int          kind;
      logic [31:0] tdat;
      int          abort_k;
      logic        e_ack;
      logic        e_err;
      logic        e_to;
      logic [31:0] e_dat;
      int          e_cycles;
   } vec_t;

   int nchk  = 0;
   int nfail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input int wt, input int k,
                               input logic [31:0] td, input int ab,
                               input logic ea, input logic ee, input logic et,
                               input logic [31:0] ed, input int ec);
      vec_t v;
      v.we = w; v.adr = a; v.wdat = d; v.sel = s; v.waits = wt; v.kind = k;
      v.tdat = td; v.abort_k = ab; v.e_ack = ea; v.e_err = ee; v.e_to = et;
      v.e_dat = ed; v.e_cycles = ec;
      return v;
   endfunction

   // Outcome derived directly from the transaction rules, not from any state machine.
   function automatic vec_t ref_model(input vec_t v);
      vec_t r = v;
      logic timed   = (v.kind == K_SIL) || (v.waits + 1 > TO);
      logic aborted = (v.abort_k != 0);
      r.e_cycles = timed ? TO : v.waits + 1;
      r.e_ack    = !aborted && !timed && (v.kind == K_ACK);
      r.e_err    = !aborted && (timed || v.kind == K_ERR);
      r.e_to     = !aborted && timed;
      r.e_dat    = r.e_ack ? v.tdat : 32'h0;
      return r;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_ack"}, ack, 1'b0);
      chk({tag, "_err"}, err, 1'b0);
      chk({tag, "_timeout"}, timeout, 1'b0);
      chk({tag, "_t_cyc"}, t_cyc, 1'b0);
      chk({tag, "_t_stb"}, t_stb, 1'b0);
      chk({tag, "_t_we"}, t_we, 1'b0);
      chk({tag, "_t_adr"}, t_adr, 32'h0);
      chk({tag, "_t_dat_w"}, t_dat_w, 32'h0);
      chk({tag, "_t_sel"}, t_sel, 4'h0);
      chk({tag, "_dat_r"}, dat_r, 32'h0);
   endtask

   // One initiator transaction against a scripted target; DUT must be idle on entry.
   task automatic run_txn(input string tag, input vec_t v);
      cyc = 1'b1; stb = 1'b1; we = v.we; adr = v.adr; dat_w = v.wdat; sel = v.sel;
      t_ack = 1'b0; t_err = 1'b0; t_dat_r = $urandom;
      tick();
      chk({tag, "_req_t_cyc"}, t_cyc, 1'b1);
      chk({tag, "_req_t_stb"}, t_stb, 1'b1);
      chk({tag, "_req_t_adr"}, t_adr, v.adr);
      chk({tag, "_req_t_we"}, t_we, v.we);
      chk({tag, "_req_t_dat_w"}, t_dat_w, v.wdat);
      chk({tag, "_req_t_sel"}, t_sel, v.sel);
      for (int k = 1; k <= v.e_cycles; k++) begin
         t_dat_r = $urandom;
         if (k == v.waits + 1 && v.kind != K_SIL) begin
            t_ack   = 1'b1;
            t_err   = (v.kind == K_ERR);
            t_dat_r = v.tdat;
         end else begin
            t_ack = 1'b0;
            t_err = 1'b0;
         end
         if (v.abort_k == k) begin
            cyc = 1'b0;
            stb = 1'b0;
         end
         tick();
         t_ack = 1'b0;
         t_err = 1'b0;
         if (k < v.e_cycles) begin
            chk({tag, "_wait_t_stb"}, t_stb, 1'b1);
            chk({tag, "_wait_t_cyc"}, t_cyc, 1'b1);
            chk({tag, "_wait_t_adr"}, t_adr, v.adr);
            chk({tag, "_wait_ack"}, ack, 1'b0);
            chk({tag, "_wait_err"}, err, 1'b0);
         end else begin
            chk({tag, "_rsp_t_cyc"}, t_cyc, 1'b0);
            chk({tag, "_rsp_t_stb"}, t_stb, 1'b0);
            chk({tag, "_rsp_ack"}, ack, v.e_ack);
            chk({tag, "_rsp_err"}, err, v.e_err);
            chk({tag, "_rsp_timeout"}, timeout, v.e_to);
            if (v.e_ack && !v.we) chk({tag, "_rsp_dat_r"}, dat_r, v.e_dat);
            if (v.e_err) chk({tag, "_rsp_dat_r_zero"}, dat_r, 32'h0);
         end
      end
      cyc = 1'b0; stb = 1'b0;
      tick();
      chk({tag, "_post_ack"}, ack, 1'b0);
      chk({tag, "_post_err"}, err, 1'b0);
      chk({tag, "_post_timeout"}, timeout, 1'b0);
      chk({tag, "_post_t_cyc"}, t_cyc, 1'b0);
   endtask

   vec_t tbl[8];
   logic [31:0] blist[8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      adr = 32'h0; dat_w = 32'h0; sel = 4'h0;
      t_dat_r = 32'h0; t_ack = 1'b0; t_err = 1'b0;

      tbl[0] = mk(1'b0, 32'h1000_0040, 32'h0, 4'hF, 0, K_ACK, 32'hDEAD_BEEF, 0,
                  1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1);
      tbl[1] = mk(1'b1, 32'h2000_0010, 32'hA5A5_0001, 4'b0011, 3, K_ACK, 32'h0, 0,
                  1'b1, 1'b0, 1'b0, 32'h0, 4);
      tbl[2] = mk(1'b0, 32'h2000_0020, 32'h0, 4'hF, 2, K_ERR, 32'h1234_5678, 0,
                  1'b0, 1'b1, 1'b0, 32'h0, 3);
      tbl[3] = mk(1'b0, 32'h2000_0030, 32'h0, 4'hF, 0, K_SIL, 32'h0, 0,
                  1'b0, 1'b1, 1'b1, 32'h0, 16);
      tbl[4] = mk(1'b0, 32'h2000_0040, 32'h0, 4'hF, 15, K_ACK, 32'hCAFE_F00D, 0,
                  1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 16);
      tbl[5] = mk(1'b0, 32'h2000_0050, 32'h0, 4'hF, 16, K_ACK, 32'h1111_2222, 0,
                  1'b0, 1'b1, 1'b1, 32'h0, 16);
      tbl[6] = mk(1'b0, 32'h2000_0060, 32'h0, 4'hF, 5, K_ACK, 32'h3333_4444, 2,
                  1'b0, 1'b0, 1'b0, 32'h0, 6);
      tbl[7] = mk(1'b1, 32'h2000_0070, 32'h7777_8888, 4'hC, 0, K_SIL, 32'h0, 3,
                  1'b0, 1'b0, 1'b0, 32'h0, 16);

      tick();
      tick();
      chk_zero("reset");
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_txn($sformatf("tbl%0d", i), tbl[i]);
      end

      // Reset while the target is still being held in a request.
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0000; sel = 4'hF;
      tick();
      tick();
      chk("midrst_t_stb_before", t_stb, 1'b1);
      reset_n = 1'b0;
      tick();
      chk_zero("midrst");
      reset_n = 1'b1; cyc = 1'b0; stb = 1'b0;
      tick();
      chk("midrst_idle_ack", ack, 1'b0);
      run_txn("after_rst", ref_model(mk(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1, K_ACK,
                                         32'h0BAD_F00D, 0, 1'b0, 1'b0, 1'b0, 32'h0, 0)));

      // Back-to-back reads with stb held through the idle cycle; target acks immediately.
      begin
         int idx = 0;
         int last_c = -1;
         for (int i = 0; i < 8; i++) blist[i] = 32'h4000_0000 + 32'(i * 16);
         cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = blist[0]; t_ack = 1'b0;
         for (int c = 0; c < 60 && idx < 8; c++) begin
            tick();
            t_ack = 1'b0;
            if (ack) begin
               chk("b2b_dat_r", dat_r, blist[idx] ^ B2B_KEY);
               chk("b2b_err", err, 1'b0);
               if (last_c >= 0) chk("b2b_interval", 64'(c - last_c), 64'd3);
               last_c = c;
               idx++;
               if (idx < 8) begin
                  adr = blist[idx];
               end else begin
                  cyc = 1'b0;
                  stb = 1'b0;
               end
            end
            if (t_stb) begin
               chk("b2b_t_adr", t_adr, blist[idx]);
               t_ack   = 1'b1;
               t_dat_r = t_adr ^ B2B_KEY;
            end
         end
         chk("b2b_count", 64'(idx), 64'd8);
         t_ack = 1'b0;
         tick();
         chk("b2b_tail_ack", ack, 1'b0);
         tick();
      end

      // Randomized transactions against the rule-level model.
      for (int n = 0; n < 40; n++) begin
         vec_t v;
         int r = $urandom_range(0, 9);
         v = mk($urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom_range(0, 15)),
                0, K_ACK, $urandom, 0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
         v.kind  = (r < 6) ? K_ACK : ((r < 8) ? K_ERR : K_SIL);
         v.waits = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 4);
         v = ref_model(v);
         if ($urandom_range(0, 7) == 0) begin
            v.abort_k = $urandom_range(1, v.e_cycles);
            v = ref_model(v);
         end
         run_txn($sformatf("rnd%0d", n), v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
